// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg: shared HI/LO divider constants (state encodings, handshake levels, bus types)
package hilo_div_ctrl_pkg;
  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] RegBus;
  localparam RegBus ZeroWord = '0;
  localparam logic [1:0] FREE = 2'b00;
  localparam logic [1:0] BYZERO = 2'b01;
  localparam logic [1:0] ON = 2'b10;
  localparam logic [1:0] END = 2'b11;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
endpackage

// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_ctrl_if: EX-stage divide request / HI/LO result bundle (master = issuer, slave = divider)
interface hilo_div_ctrl_if #(parameter int DATA_W = hilo_div_ctrl_pkg::DATA_W);
  logic start_i, signed_i, annul_i, busy_o, ready_o, hilo_we_o;
  logic [DATA_W-1:0] opdata1_i, opdata2_i, hi_o, lo_o;
  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input busy_o, ready_o, hilo_we_o, hi_o, lo_o
  );
  modport slave (
    input start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational radix-2 restoring division step on {rem, quo}
module hilo_div_step #(parameter int DATA_W = 32) (
  input logic [DATA_W-1:0] rem_i,
  input logic [DATA_W-1:0] quo_i,
  input logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0] diff;
  assign diff = {rem_i, quo_i[DATA_W-1]} - {1'b0, dvs_i};
  assign rem_o = diff[DATA_W] ? {rem_i[DATA_W-2:0], quo_i[DATA_W-1]} : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], !diff[DATA_W]};
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: multi-cycle DIV/DIVU sequencer writing HI=rem, LO=quo; HILO_DIV_EARLY_EN adds early-out when |dividend| < |divisor|
module hilo_div_ctrl #(
  parameter int DATA_W = hilo_div_ctrl_pkg::DATA_W,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  hilo_div_ctrl_if.slave div
);
  import hilo_div_ctrl_pkg::*;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_rem_q, neg_rem_d, neg_quo_q, neg_quo_d, we_q;
  logic [DATA_W-1:0] a_mag, b_mag, rem_n, quo_n;
  logic accept, early, last;
  assign accept = rst && state_q == FREE && div.start_i == DivStart && !div.annul_i;
  assign a_mag = div.signed_i && div.opdata1_i[DATA_W-1] ? -div.opdata1_i : div.opdata1_i;
  assign b_mag = div.signed_i && div.opdata2_i[DATA_W-1] ? -div.opdata2_i : div.opdata2_i;
  assign last = cnt_q == CNT_W'(DATA_W - 1);
  hilo_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n)
  );
`ifdef HILO_DIV_EARLY_EN
  logic [DATA_W-1:0] cmp_rem, cmp_quo;
  hilo_div_step #(.DATA_W(DATA_W)) u_cmp (
    .rem_i(a_mag >> 1), .quo_i({a_mag[0], {(DATA_W-1){1'b0}}}), .dvs_i(b_mag),
    .rem_o(cmp_rem), .quo_o(cmp_quo)
  );
  assign early = !cmp_quo[0];
`else
  assign early = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    neg_rem_d = neg_rem_q;
    neg_quo_d = neg_quo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FREE) begin
      if (accept) begin
        rem_d = '0;
        quo_d = a_mag;
        dvs_d = b_mag;
        neg_rem_d = div.signed_i && div.opdata1_i[DATA_W-1];
        neg_quo_d = div.signed_i && (div.opdata1_i[DATA_W-1] ^ div.opdata2_i[DATA_W-1]);
        cnt_d = '0;
        state_d = b_mag == '0 ? BYZERO : early ? END : ON;
        hi_d = b_mag != '0 && early ? div.opdata1_i : '0;
        lo_d = '0;
      end
    end else if (state_q == END) begin
      state_d = div.start_i == DivStart ? END : FREE;
    end else if (div.annul_i) begin
      state_d = FREE;
    end else if (state_q == BYZERO) begin
      state_d = END;
    end else begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? END : ON;
      hi_d = last ? (neg_rem_q ? -rem_n : rem_n) : hi_q;
      lo_d = last ? (neg_quo_q ? -quo_n : quo_n) : lo_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FREE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      neg_rem_q <= neg_rem_d;
      neg_quo_q <= neg_quo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      we_q <= state_d == END && state_q != END;
    end
  end
  assign div.busy_o = accept || state_q == BYZERO || state_q == ON;
  assign div.ready_o = state_q == END ? DivResultReady : DivResultNotReady;
  assign div.hilo_we_o = we_q;
  assign div.hi_o = hi_q;
  assign div.lo_o = lo_q;
endmodule
